// File: rtl/key_matrix_scanner_if.sv
// key_matrix_scanner_if: valid/ready stream of debounced key press/release events
interface key_matrix_scanner_if #(parameter int KW = 6);
  logic          event_valid;
  logic          event_ready;
  logic [KW-1:0] event_index;
  logic          event_pressed;
  modport master (output event_valid, event_index, event_pressed, input event_ready);
  modport slave (input event_valid, event_index, event_pressed, output event_ready);
endinterface

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: column-strobed switch matrix scan with per-key debounce and event stream
module key_matrix_scanner #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [ROWS-1:0]      rows_in,
  output logic [COLS-1:0]      cols_out,
  output logic [ROWS*COLS-1:0] keys,
  output logic                 frame_done,
  key_matrix_scanner_if.master ev
);
  localparam int KW = $clog2(ROWS*COLS);
  localparam int RBW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CBW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS+1);
  if (SETTLE_CYCLES < 3) begin : g_settle_chk
    $error("SETTLE_CYCLES must be at least 3");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_deb_chk
    $error("DEBOUNCE_SCANS must be at least 1");
  end
  typedef enum logic [1:0] {IDLE, DRIVE, UPDATE} state_t;
  state_t          state;
  logic [ROWS-1:0] sync1, row_sync, row_sample;
  logic [CBW-1:0]  c, nc;
  logic [RBW-1:0]  r;
  logic [SW-1:0]   s;
  logic [CW-1:0]   cnt [ROWS*COLS];
  logic [KW-1:0]   k;
  logic            raw, commit, stall, last_row, last_col;
  assign k = KW'(int'(r) * COLS + int'(c));
  assign raw = ~row_sample[r];
  assign commit = raw != keys[k] && cnt[k] == CW'(DEBOUNCE_SCANS-1);
  assign stall = commit && ev.event_valid && !ev.event_ready;
  assign last_row = r == RBW'(ROWS-1);
  assign last_col = c == CBW'(COLS-1);
  assign nc = last_col ? '0 : c + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sync1 <= '1;
      row_sync <= '1;
      row_sample <= '1;
      c <= '0;
      r <= '0;
      s <= '0;
      for (int i = 0; i < ROWS*COLS; i++) cnt[i] <= '0;
      cols_out <= '1;
      keys <= '0;
      frame_done <= 1'b0;
      ev.event_valid <= 1'b0;
      ev.event_index <= '0;
      ev.event_pressed <= 1'b0;
    end else begin
      sync1 <= rows_in;
      row_sync <= sync1;
      frame_done <= 1'b0;
      if (ev.event_valid && ev.event_ready) ev.event_valid <= 1'b0;
      case (state)
        IDLE: if (ena) begin
          state <= DRIVE;
          s <= '0;
          cols_out <= ~(COLS'(1) << c);
        end
        DRIVE: begin
          s <= s + 1'b1;
          if (s == SW'(SETTLE_CYCLES-1)) begin
            row_sample <= row_sync;
            r <= '0;
            state <= UPDATE;
          end
        end
        default: if (!stall) begin
          if (raw == keys[k]) cnt[k] <= '0;
          else if (commit) begin
            keys[k] <= raw;
            cnt[k] <= '0;
            ev.event_valid <= 1'b1;
            ev.event_index <= k;
            ev.event_pressed <= raw;
          end else cnt[k] <= cnt[k] + 1'b1;
          r <= r + 1'b1;
          if (last_row) begin
            c <= nc;
            frame_done <= last_col;
            s <= '0;
            state <= ena ? DRIVE : IDLE;
            cols_out <= ena ? ~(COLS'(1) << nc) : '1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: directed scenarios with an event scoreboard and a decoupled monitor
module tb_key_matrix_scanner;
  logic        clk = 0, rst = 1, ena = 0;
  logic [7:0]  rows_in, cols_out;
  logic [63:0] keys, closed = '0;
  logic        frame_done;
  logic [6:0]  q[$];
  int          checks = 0, errors = 0;
  key_matrix_scanner_if #(.KW(6)) ev();
  key_matrix_scanner dut (.clk(clk), .rst(rst), .ena(ena), .rows_in(rows_in), .cols_out(cols_out),
                          .keys(keys), .frame_done(frame_done), .ev(ev));
  always #5 clk = ~clk;
  // a closed key pulls its row low while its column is driven low
  always_comb begin
    rows_in = '1;
    for (int i = 0; i < 8; i++) rows_in[i] = ~|(closed[i*8 +: 8] & ~cols_out);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst && ev.event_valid && ev.event_ready) begin
    if (q.size() == 0) chk("unexpected_event", {ev.event_index, ev.event_pressed}, 7'h7f);
    else chk("event", {ev.event_index, ev.event_pressed}, q.pop_front());
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_frame();
    int n = 0;
    do begin tick(1); n++; end while (!frame_done && n < 300);
    if (!frame_done) chk("frame_timeout", 0, 1);
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!ev.event_valid && n < 300) begin tick(1); n++; end
    if (!ev.event_valid) chk("valid_timeout", 0, 1);
  endtask
  task automatic pulse_ready();
    ev.event_ready = 1;
    tick(1);
    ev.event_ready = 0;
    tick(5);
  endtask
  initial begin
    int n;
    ev.event_ready = 1;
    tick(3);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      chk("idle_cols", cols_out, 8'hff);
      chk("idle_valid", ev.event_valid, 0);
      tick(1);
    end
    chk("idle_keys", keys, 0);
    ena = 1;
    tick(1);
    chk("first_col", cols_out, 8'hfe);
    tick(11);
    chk("col0_held", cols_out, 8'hfe);
    tick(1);
    chk("second_col", cols_out, 8'hfd);
    wait_frame();
    closed[21] = 1;
    q.push_back({6'd21, 1'b1});
    wait_frame();
    chk("press_not_early", keys[21], 0);
    wait_frame();
    chk("press_keys", keys, 64'd1 << 21);
    closed[21] = 0;
    q.push_back({6'd21, 1'b0});
    wait_frame();
    chk("release_not_early", keys[21], 1);
    wait_frame();
    chk("release_keys", keys, 0);
    closed[21] = 1;
    wait_frame();
    closed[21] = 0;
    wait_frame();
    n = 0;
    do begin tick(1); n++; end while (!frame_done && n < 300);
    chk("frame_period", n, 96);
    chk("bounce_keys", keys, 0);
    wait_frame();
    tick(37);
    chk("col3_drive", cols_out, 8'hf7);
    ena = 0;
    tick(10);
    chk("col3_update", cols_out, 8'hf7);
    tick(1);
    chk("ena_off_idle", cols_out, 8'hff);
    tick(20);
    chk("stays_idle", cols_out, 8'hff);
    ena = 1;
    tick(1);
    chk("resume_col4", cols_out, 8'hef);
    wait_frame();
    ev.event_ready = 0;
    closed[1] = 1;
    closed[25] = 1;
    closed[57] = 1;
    q.push_back({6'd1, 1'b1});
    q.push_back({6'd25, 1'b1});
    q.push_back({6'd57, 1'b1});
    wait_frame();
    wait_valid();
    tick(10);
    chk("stall_index", ev.event_index, 1);
    chk("stall_cols", cols_out, 8'hfd);
    pulse_ready();
    chk("stall2_index", ev.event_index, 25);
    chk("stall2_cols", cols_out, 8'hfd);
    pulse_ready();
    chk("third_index", ev.event_index, 57);
    pulse_ready();
    chk("drained_valid", ev.event_valid, 0);
    chk("resumed_cols", cols_out, 8'hfb);
    chk("bp_keys", keys, (64'd1 << 1) | (64'd1 << 25) | (64'd1 << 57));
    closed = '0;
    wait_frame();
    wait_valid();
    tick(3);
    chk("rel_stall_cols", cols_out, 8'hfd);
    rst = 1;
    tick(1);
    chk("rst_cols", cols_out, 8'hff);
    chk("rst_keys", keys, 0);
    chk("rst_valid", ev.event_valid, 0);
    chk("rst_index", ev.event_index, 0);
    chk("rst_pressed", ev.event_pressed, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 0;
    ev.event_ready = 1;
    wait_frame();
    wait_frame();
    wait_frame();
    chk("post_rst_keys", keys, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
